// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline stages.
package mips_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      MODE_ADVANCE,
      MODE_HOLD,
      MODE_FLUSH
   } fetch_mode_e;

   function automatic int unsigned word_idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: asynchronous read, synchronous write, read-before-write.
module imem_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   // Contents are never reset so a program loaded during reset survives it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem lookup and the IF/ID pipeline register.
module if_stage
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        imem_we,
   input  logic [31:0] imem_addr,
   input  logic [31:0] imem_wdata,
   output logic [31:0] PC_out,
   output logic [31:0] Instruction_out,
   output logic        valid_out,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
);

   localparam int unsigned AW = word_idx_width(IMEM_DEPTH);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   logic [31:0] pc_plus4;
   logic [31:0] imem_rdata;
   fetch_mode_e mode;
   logic        unused_bits;

   imem_ram #(
      .DEPTH (IMEM_DEPTH),
      .AW    (AW)
   ) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (imem_addr[AW+1:2]),
      .wdata (imem_wdata),
      .raddr (pc_q[AW+1:2]),
      .rdata (imem_rdata)
   );

   always_comb begin
      unused_bits = ^{branch_target[1:0], imem_addr[31:AW+2], imem_addr[1:0]};
   end

   always_comb begin
      mode = MODE_ADVANCE;
      if (branch_taken) begin
         mode = MODE_FLUSH;
      end else if (stall) begin
         mode = MODE_HOLD;
      end
   end

   always_comb begin
      pc_plus4    = pc_q + 32'd4;
      pc_d        = pc_q;
      pc_out_d    = pc_out_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      fetch_cnt_d = fetch_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (mode)
         MODE_FLUSH: begin
            pc_d        = {branch_target[31:2], 2'b00};
            pc_out_d    = '0;
            instr_d     = NOP;
            valid_d     = 1'b0;
            flush_cnt_d = flush_cnt_q + 32'd1;
         end
         MODE_ADVANCE: begin
            pc_d        = pc_plus4;
            pc_out_d    = pc_plus4;
            instr_d     = imem_rdata;
            valid_d     = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         pc_out_q    <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         pc_out_q    <= pc_out_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      PC_out          = pc_out_q;
      Instruction_out = instr_q;
      valid_out       = valid_q;
      fetch_count     = fetch_cnt_q;
      flush_count     = flush_cnt_q;
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed checks of the fetch stage: sequential fetch, stall, flush, wrap, reset reload.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] PC_out;
   logic [31:0] Instruction_out;
   logic        valid_out;
   logic [31:0] fetch_count;
   logic [31:0] flush_count;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   if_stage #(
      .IMEM_DEPTH (64),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .imem_we         (imem_we),
      .imem_addr       (imem_addr),
      .imem_wdata      (imem_wdata),
      .PC_out          (PC_out),
      .Instruction_out (Instruction_out),
      .valid_out       (valid_out),
      .fetch_count     (fetch_count),
      .flush_count     (flush_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic e_v, input logic [31:0] e_fc, input logic [31:0] e_flc);
      n_assert++;
      assert (PC_out === e_pc) else begin
         n_fail++;
         $error("FAIL %s PC_out got %h exp %h", tag, PC_out, e_pc);
      end
      n_assert++;
      assert (Instruction_out === e_ins) else begin
         n_fail++;
         $error("FAIL %s Instruction_out got %h exp %h", tag, Instruction_out, e_ins);
      end
      n_assert++;
      assert (valid_out === e_v) else begin
         n_fail++;
         $error("FAIL %s valid_out got %b exp %b", tag, valid_out, e_v);
      end
      n_assert++;
      assert (fetch_count === e_fc) else begin
         n_fail++;
         $error("FAIL %s fetch_count got %0d exp %0d", tag, fetch_count, e_fc);
      end
      n_assert++;
      assert (flush_count === e_flc) else begin
         n_fail++;
         $error("FAIL %s flush_count got %0d exp %0d", tag, flush_count, e_flc);
      end
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      imem_we    = 1'b1;
      imem_addr  = addr;
      imem_wdata = data;
      tick();
      imem_we    = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      imem_we       = 1'b0;
      imem_addr     = '0;
      imem_wdata    = '0;

      // Program loaded while reset is held.
      load(32'h00, 32'h2001_0001);
      load(32'h04, 32'h2002_0002);
      load(32'h08, 32'h2003_0003);
      load(32'h0C, 32'h2004_0004);
      load(32'h10, 32'h2005_0005);
      load(32'h14, 32'h2006_0006);
      load(32'hFC, 32'h2003_F03F);
      chk("reset", 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);

      reset = 1'b0;
      tick(); chk("seq0", 32'h04, 32'h2001_0001, 1'b1, 32'd1, 32'd0);
      tick(); chk("seq1", 32'h08, 32'h2002_0002, 1'b1, 32'd2, 32'd0);

      stall = 1'b1;
      tick(); chk("stall1", 32'h08, 32'h2002_0002, 1'b1, 32'd2, 32'd0);
      tick(); chk("stall2", 32'h08, 32'h2002_0002, 1'b1, 32'd2, 32'd0);
      tick(); chk("stall3", 32'h08, 32'h2002_0002, 1'b1, 32'd2, 32'd0);
      stall = 1'b0;
      tick(); chk("seq2", 32'h0C, 32'h2003_0003, 1'b1, 32'd3, 32'd0);

      branch_taken  = 1'b1;
      branch_target = 32'h10;
      tick(); chk("flush", 32'h0, 32'h0, 1'b0, 32'd3, 32'd1);
      branch_taken = 1'b0;
      tick(); chk("target", 32'h14, 32'h2005_0005, 1'b1, 32'd4, 32'd1);
      tick(); chk("target+1", 32'h18, 32'h2006_0006, 1'b1, 32'd5, 32'd1);

      branch_taken  = 1'b1;
      stall         = 1'b1;
      branch_target = 32'h04;
      tick(); chk("br_stall", 32'h0, 32'h0, 1'b0, 32'd5, 32'd2);
      branch_taken = 1'b0;
      stall        = 1'b0;
      tick(); chk("br_stall_tgt", 32'h08, 32'h2002_0002, 1'b1, 32'd6, 32'd2);

      branch_taken  = 1'b1;
      branch_target = 32'hFE;
      tick(); chk("wrap_flush", 32'h0, 32'h0, 1'b0, 32'd6, 32'd3);
      branch_taken = 1'b0;
      tick(); chk("word63", 32'h100, 32'h2003_F03F, 1'b1, 32'd7, 32'd3);
      tick(); chk("wrap0", 32'h104, 32'h2001_0001, 1'b1, 32'd8, 32'd3);

      // PC now addresses word 1; overwrite it in the same cycle.
      load(32'h04, 32'h1111_1111);
      chk("rbw_old", 32'h108, 32'h2002_0002, 1'b1, 32'd9, 32'd3);
      branch_taken  = 1'b1;
      branch_target = 32'h04;
      tick(); chk("rbw_flush", 32'h0, 32'h0, 1'b0, 32'd9, 32'd4);
      branch_taken = 1'b0;
      tick(); chk("rbw_new", 32'h08, 32'h1111_1111, 1'b1, 32'd10, 32'd4);

      reset = 1'b1;
      load(32'h00, 32'hDEAD_BEEF);
      chk("reset_mid1", 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
      tick(); chk("reset_mid2", 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      tick(); chk("after_reset", 32'h04, 32'hDEAD_BEEF, 1'b1, 32'd1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, reads a word-addressed instruction memory, and registers the fetched word into the IF/ID pipeline register. It feeds the decode stage directly: `PC_out` (already PC+4) and `Instruction_out`. It accepts a stall from the hazard unit and a branch redirect/flush from the stage that resolves branches.

## Interface
- `IMEM_DEPTH`, 64: instruction memory size in 32-bit words; power of two.
- `RESET_PC`, 32'h00000000: PC value after reset; word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `stall` input 1: hold PC and the IF/ID register this cycle.
- `branch_taken` input 1: redirect fetch and flush IF/ID.
- `branch_target` input 32: new PC when `branch_taken`; bits [1:0] ignored.
- `imem_we` input 1: instruction-memory load strobe (bench/boot loader).
- `imem_addr` input 32: byte address for load; word index = bits [log2(IMEM_DEPTH)+1:2].
- `imem_wdata` input 32: word to load.
- `PC_out` output 32: IF/ID register, PC+4 of the held instruction.
- `Instruction_out` output 32: IF/ID register, fetched instruction.
- `valid_out` output 1: IF/ID holds a real instruction (0 = bubble).
- `fetch_count` output 32: instructions registered into IF/ID since reset.
- `flush_count` output 32: flushes performed since reset.

## Operation
- The PC register addresses imem by word index PC[log2(IMEM_DEPTH)+1:2]. Higher bits are ignored, so fetch wraps modulo IMEM_DEPTH words.
- Imem read is asynchronous within IF. Imem write is synchronous on `imem_we`.
- Per-cycle priority: `reset` > `branch_taken` > `stall` > normal.
- Reset:
  - PC <= RESET_PC.
  - `PC_out`, `Instruction_out`, and both counters <= 0.
  - `valid_out` <= 0.
  - Imem contents are not cleared.
- `branch_taken`:
  - PC <= {branch_target[31:2], 2'b00}.
  - IF/ID <= bubble: `Instruction_out` = 32'h00000000 (sll $0 NOP), `valid_out` = 0, `PC_out` = 0.
  - `flush_count` += 1.
  - Overrides a simultaneous `stall`.
- `stall` only: PC, `PC_out`, `Instruction_out`, `valid_out`, and counters all hold.
- Normal:
  - IF/ID <= {PC+4, imem[PC], 1}.
  - PC <= PC+4, 32-bit wrap.
  - `fetch_count` += 1.
- Counters are 32-bit and wrap silently.
- `imem_we` is honoured in every cycle, including during reset and stall, so a program can be loaded while `reset` is held.
- Write and fetch to the same word in the same cycle: the fetch returns the old word (read-before-write); the new word is visible from the next cycle.
- No FSM beyond the three per-cycle modes (flush / hold / advance). All state is the PC, IF/ID, and counters.

## Timing
- Latency: the instruction at PC appears on `Instruction_out` one cycle after PC is presented, i.e. the edge following the fetch.
- Branch penalty:
  - The branch asserted in cycle N yields a bubble in IF/ID after edge N.
  - The target instruction appears in IF/ID after edge N+1.
  - The decode-side flush of the instruction already in ID is owned by the downstream register, not by this block.
- Stall for k cycles: outputs stable for k cycles, then resume with no lost or duplicated instruction.
- Reset deasserted at edge N: the first `valid_out`=1 is after edge N+1, with `Instruction_out` = imem[RESET_PC], `PC_out` = RESET_PC+4.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `mips_pkg`:
  - NOP constant 32'h00000000.
  - Word-index width helper (log2 of IMEM_DEPTH).
  - Default RESET_PC.
- One sub-module `imem_ram`: async read, sync write, IMEM_DEPTH words, read-before-write semantics.
- PC logic, IF/ID register, and counters live in `if_stage` itself.

## Test plan
- Sequential fetch:
  - Load words 0x20010001, 0x20020002, 0x20030003 at 0x0, 0x4, 0x8; release reset.
  - Required: `Instruction_out` sequence matches them, with `PC_out` 4, 8, 12 and `valid_out`=1.
  - Required: `fetch_count`=3.
- Stall:
  - Assert `stall` for 3 cycles while IF/ID holds 0x20020002.
  - Required: outputs are unchanged for 3 cycles, then 0x20030003 follows; `fetch_count` does not advance during the stall.
- Branch flush:
  - Assert `branch_taken` with `branch_target`=0x00000010 while fetching 0x8.
  - Required: next cycle `Instruction_out`=0, `valid_out`=0, `flush_count`=1.
  - Required: the following cycle `Instruction_out`=imem[4], `PC_out`=0x14.
- Branch + stall same cycle:
  - Required: the flush wins; PC=target, bubble inserted.
- Wrap and alignment:
  - With IMEM_DEPTH=64, `branch_target`=0x000000FE.
  - Required: fetch word 63 with `PC_out`=0x100; the next fetch reads word 0.
- Reset mid-run and load during reset:
  - Assert `reset` for 2 cycles while writing 0xDEADBEEF to 0x0.
  - Required: all outputs are 0 during reset, and the first fetch after release returns 0xDEADBEEF.
